// File: rtl/isa_types_pkg.sv
// Core ISA-wide types shared across the hart: datapath width and store widths.
package isa_types;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WW_BYTE = 2'd0,
        WW_HALF = 2'd1,
        WW_WORD = 2'd2
    } write_width_t;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Types used by the fetch/LSU memory arbiter.
package mem_arb_types;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes (fetch port I, load/store port D) plus the memory-side bus.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic                    i_req;
    logic [XLEN-1:0]         i_addr;
    logic                    i_gnt;
    logic                    i_rvalid;
    logic [XLEN-1:0]         i_rdata;

    logic                    d_req;
    logic                    d_we;
    logic [XLEN-1:0]         d_addr;
    isa_types::write_width_t d_wwidth;
    logic [XLEN-1:0]         d_wdata;
    logic                    d_gnt;
    logic                    d_rvalid;
    logic [XLEN-1:0]         d_rdata;
    logic                    d_wack;

    logic [XLEN-1:0]         mem_addr;
    isa_types::write_width_t mem_wwidth;
    logic                    mem_wenable;
    logic [XLEN-1:0]         mem_wdata;
    logic [XLEN-1:0]         mem_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wwidth, d_wdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_wack
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wwidth, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_wack,
               mem_addr, mem_wwidth, mem_wenable, mem_wdata
    );

    modport memory (
        input  mem_addr, mem_wwidth, mem_wenable, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the port that did not win last time wins.
module rr_pick2
    import mem_arb_types::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output port_id_t   granted,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        granted     = PORT_I;
        if (req[PORT_I] && req[PORT_D]) begin
            granted = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (req[PORT_D]) begin
            granted = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port memory between fetch (read-only) and load/store ports,
// owning the memory controls and the read-latency countdown.
module mem_arbiter
    import mem_arb_types::*;
#(
    parameter int XLEN         = isa_types::XLEN,
    parameter int READ_LATENCY = 2
) (
    input logic           clock,
    input logic           reset,
    mem_arbiter_if.slave  bus
);

    localparam int CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    typedef logic [CW-1:0] count_t;
    localparam count_t COUNT_INIT = count_t'(READ_LATENCY);

    arb_state_t              state, state_next;
    port_id_t                owner, last_grant, granted;
    logic                    grant_valid;
    logic                    grant_take;
    count_t                  count;
    logic [XLEN-1:0]         lat_addr;
    logic [XLEN-1:0]         lat_wdata;
    isa_types::write_width_t lat_wwidth;

    rr_pick2 u_pick (
        .req         ({bus.d_req, bus.i_req}),
        .last_grant  (last_grant),
        .granted     (granted),
        .grant_valid (grant_valid)
    );

    assign grant_take = (state == ARB_IDLE) && grant_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= PORT_I;
            last_grant <= PORT_I;
            count      <= COUNT_INIT;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wwidth <= isa_types::WW_WORD;
        end else begin
            state <= state_next;
            if (grant_take) begin
                owner      <= granted;
                last_grant <= granted;
                count      <= COUNT_INIT;
                lat_addr   <= (granted == PORT_D) ? bus.d_addr : bus.i_addr;
                lat_wdata  <= bus.d_wdata;
                lat_wwidth <= bus.d_wwidth;
            end else if (state == ARB_READ && count != '0) begin
                count <= count - count_t'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_next = (granted == PORT_D && bus.d_we) ? ARB_WRITE : ARB_READ;
                end
            end
            ARB_READ: begin
                if (count == '0) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_WRITE: state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.i_gnt       = 1'b0;
        bus.d_gnt       = 1'b0;
        bus.i_rvalid    = 1'b0;
        bus.d_rvalid    = 1'b0;
        bus.d_wack      = 1'b0;
        bus.i_rdata     = bus.mem_rdata;
        bus.d_rdata     = bus.mem_rdata;
        bus.mem_addr    = bus.i_addr;
        bus.mem_wwidth  = lat_wwidth;
        bus.mem_wdata   = lat_wdata;
        bus.mem_wenable = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    bus.i_gnt = (granted == PORT_I);
                    bus.d_gnt = (granted == PORT_D);
                end
            end
            ARB_READ: begin
                bus.mem_addr = lat_addr;
                if (count == '0) begin
                    bus.i_rvalid = (owner == PORT_I);
                    bus.d_rvalid = (owner == PORT_D);
                end
            end
            ARB_WRITE: begin
                bus.mem_addr    = lat_addr;
                bus.mem_wenable = 1'b1;
                bus.d_wack      = 1'b1;
            end
            default: ;
        endcase
        // Strobes are suppressed while reset is held so an aborted op never completes
        // and a grant is never handed out that the state register will not honour.
        if (reset) begin
            bus.i_gnt       = 1'b0;
            bus.d_gnt       = 1'b0;
            bus.i_rvalid    = 1'b0;
            bus.d_rvalid    = 1'b0;
            bus.d_wack      = 1'b0;
            bus.mem_wenable = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: latency-checked memory model plus expected-data queues.
module tb_mem_arbiter;
    import mem_arb_types::*;
    import isa_types::*;

    logic clock;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp0_q[$];

    mem_arbiter_if #(.XLEN(32)) bus ();
    mem_arbiter_if #(.XLEN(32)) bus0 ();

    mem_arbiter #(.XLEN(32), .READ_LATENCY(2)) u_dut  (.clock(clock), .reset(reset), .bus(bus));
    mem_arbiter #(.XLEN(32), .READ_LATENCY(0)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                          input write_width_t w, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        case (w)
            WW_BYTE: r[{off, 3'b000} +: 8]        = d[7:0];
            WW_HALF: r[{off[1], 4'b0000} +: 16]   = d[15:0];
            default: r                            = d;
        endcase
        return r;
    endfunction

    // Memory for the latency-2 DUT: data is garbage unless the address was held 2 prior cycles.
    logic [31:0]  mem [0:1023];
    logic [31:0]  ref_mem [0:1023];
    logic [31:0]  mem_prev = '0;
    int unsigned  mem_held = 0;
    always @(posedge clock) begin
        if (bus.mem_wenable === 1'b1)
            mem[bus.mem_addr[11:2]] <= merge(mem[bus.mem_addr[11:2]], bus.mem_addr[1:0],
                                             bus.mem_wwidth, bus.mem_wdata);
        mem_held <= (bus.mem_addr == mem_prev) ? mem_held + 1 : 1;
        mem_prev <= bus.mem_addr;
    end
    assign bus.mem_rdata = (bus.mem_addr == mem_prev && mem_held >= 2) ?
                           mem[bus.mem_addr[11:2]] : 32'hBAD0_BAD0;

    logic [31:0] mem0 [0:1023];
    always @(posedge clock) begin
        if (bus0.mem_wenable === 1'b1)
            mem0[bus0.mem_addr[11:2]] <= merge(mem0[bus0.mem_addr[11:2]], bus0.mem_addr[1:0],
                                               bus0.mem_wwidth, bus0.mem_wdata);
    end
    assign bus0.mem_rdata = mem0[bus0.mem_addr[11:2]];

    task automatic req_i(input logic [31:0] addr, output int gcyc);
        @(posedge clock); #1;
        bus.i_req = 1'b1; bus.i_addr = addr; gcyc = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus.i_gnt === 1'b1) begin gcyc = k; break; end
        end
        @(posedge clock); #1;
        bus.i_req = 1'b0;
    endtask

    task automatic req_d(input logic we, input logic [31:0] addr, input write_width_t w,
                         input logic [31:0] data, output int gcyc);
        @(posedge clock); #1;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wwidth = w; bus.d_wdata = data;
        gcyc = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus.d_gnt === 1'b1) begin gcyc = k; break; end
        end
        @(posedge clock); #1;
        bus.d_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++; if (u_dut.state !== ARB_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", u_dut.state, ARB_IDLE); end
        tests_run++; if (u_dut.last_grant !== PORT_I) begin tests_failed++; $display("FAIL reset_last_grant: got %0d expected 0", u_dut.last_grant); end
        tests_run++; if (u_dut.count !== 2'd2) begin tests_failed++; $display("FAIL reset_count: got %0d expected 2", u_dut.count); end
        tests_run++; if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.d_wack} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_strobes: got %b expected 00000", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.d_wack}); end
        tests_run++; if (bus.mem_wenable !== 1'b0) begin tests_failed++; $display("FAIL reset_wenable: got %b expected 0", bus.mem_wenable); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        tests_run++; if ({bus.i_gnt, bus.d_gnt} !== 2'b00) begin tests_failed++; $display("FAIL idle_no_gnt: got %b expected 00", {bus.i_gnt, bus.d_gnt}); end
    endtask

    task automatic test_fetch();
        logic [31:0] e;
        @(posedge clock); #1;
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        exp_i_q.push_back(32'h0050_0093);
        @(negedge clock);
        tests_run++; if (bus.i_gnt !== 1'b1) begin tests_failed++; $display("FAIL fetch_gnt_c0: got %b expected 1", bus.i_gnt); end
        tests_run++; if (bus.mem_wenable !== 1'b0) begin tests_failed++; $display("FAIL fetch_wen_c0: got %b expected 0", bus.mem_wenable); end
        @(posedge clock); #1;
        bus.i_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            tests_run++; if (bus.i_rvalid !== logic'(k == 3)) begin tests_failed++; $display("FAIL fetch_rvalid_c%0d: got %b expected %b", k, bus.i_rvalid, k == 3); end
            tests_run++; if (bus.mem_wenable !== 1'b0) begin tests_failed++; $display("FAIL fetch_wen_c%0d: got %b expected 0", k, bus.mem_wenable); end
            if (bus.i_rvalid === 1'b1 && exp_i_q.size() > 0) begin
                e = exp_i_q.pop_front();
                tests_run++; if (bus.i_rdata !== e) begin tests_failed++; $display("FAIL fetch_rdata: got %h expected %h", bus.i_rdata, e); end
            end
        end
        tests_run++; if (exp_i_q.size() != 0) begin tests_failed++; $display("FAIL fetch_drained: got %0d pending expected 0", exp_i_q.size()); end
    endtask

    task automatic do_store_check(input string nm, input logic [31:0] addr, input write_width_t w, input logic [31:0] data);
        int g;
        req_d(1'b1, addr, w, data, g);
        ref_mem[addr[11:2]] = merge(ref_mem[addr[11:2]], addr[1:0], w, data);
        tests_run++; if (g != 0) begin tests_failed++; $display("FAIL %s_gnt_cycle: got %0d expected 0", nm, g); end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock);
            tests_run++; if ({bus.mem_wenable, bus.d_wack} !== {2{logic'(k == 1)}}) begin
                tests_failed++; $display("FAIL %s_wen_wack_c%0d: got %b expected %b", nm, k, {bus.mem_wenable, bus.d_wack}, {2{logic'(k == 1)}}); end
            if (k == 1) begin
                tests_run++; if ({bus.mem_addr, bus.mem_wdata} !== {addr, data}) begin
                    tests_failed++; $display("FAIL %s_mem_bus: got %h/%h expected %h/%h", nm, bus.mem_addr, bus.mem_wdata, addr, data); end
            end
        end
    endtask

    task automatic do_load_check(input string nm, input logic [31:0] addr, input logic [31:0] expv);
        int g;
        logic [31:0] e;
        req_d(1'b0, addr, WW_WORD, 32'h0, g);
        exp_d_q.push_back(expv);
        tests_run++; if (g != 0) begin tests_failed++; $display("FAIL %s_gnt_cycle: got %0d expected 0", nm, g); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            tests_run++; if (bus.d_rvalid !== logic'(k == 3)) begin tests_failed++; $display("FAIL %s_rvalid_c%0d: got %b expected %b", nm, k, bus.d_rvalid, k == 3); end
            if (bus.d_rvalid === 1'b1 && exp_d_q.size() > 0) begin
                e = exp_d_q.pop_front();
                tests_run++; if (bus.d_rdata !== e) begin tests_failed++; $display("FAIL %s_rdata: got %h expected %h", nm, bus.d_rdata, e); end
            end
        end
        tests_run++; if (exp_d_q.size() != 0) begin tests_failed++; $display("FAIL %s_drained: got %0d pending expected 0", nm, exp_d_q.size()); end
    endtask

    task automatic test_store_load();
        do_store_check("store_word", 32'h800, WW_WORD, 32'hDEAD_BEEF);
        do_load_check("load_word", 32'h800, 32'hDEAD_BEEF);
    endtask

    task automatic test_byte_store();
        do_store_check("store_byte", 32'h801, WW_BYTE, 32'h0000_00AA);
        do_load_check("load_after_byte", 32'h800, 32'hDEAD_AAEF);
        do_store_check("store_half", 32'h802, WW_HALF, 32'h0000_1234);
        do_load_check("load_after_half", 32'h800, 32'h1234_AAEF);
    endtask

    task automatic test_round_robin();
        int order[$];
        int gcyc[$];
        logic [31:0] e;
        reset = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h4;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800;
        repeat (2) @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            tests_run++; if ((bus.i_gnt & bus.d_gnt) !== 1'b0) begin tests_failed++; $display("FAIL rr_dual_gnt_c%0d: got 1 expected 0", k); end
            if (bus.d_gnt === 1'b1) begin order.push_back(1); gcyc.push_back(k); exp_d_q.push_back(ref_mem[512]); end
            if (bus.i_gnt === 1'b1) begin order.push_back(0); gcyc.push_back(k); exp_i_q.push_back(ref_mem[1]); end
            if (bus.i_rvalid === 1'b1) begin
                tests_run++;
                if (exp_i_q.size() == 0) begin tests_failed++; $display("FAIL rr_i_rvalid_c%0d: got unexpected rvalid expected none", k); end
                else begin e = exp_i_q.pop_front(); if (bus.i_rdata !== e) begin tests_failed++; $display("FAIL rr_i_rdata: got %h expected %h", bus.i_rdata, e); end end
            end
            if (bus.d_rvalid === 1'b1) begin
                tests_run++;
                if (exp_d_q.size() == 0) begin tests_failed++; $display("FAIL rr_d_rvalid_c%0d: got unexpected rvalid expected none", k); end
                else begin e = exp_d_q.pop_front(); if (bus.d_rdata !== e) begin tests_failed++; $display("FAIL rr_d_rdata: got %h expected %h", bus.d_rdata, e); end end
            end
        end
        @(posedge clock); #1;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        tests_run++; if (order.size() != 4) begin tests_failed++; $display("FAIL rr_grant_count: got %0d expected 4", order.size()); end
        for (int j = 0; j < order.size() && j < 4; j++) begin
            tests_run++; if (order[j] != ((j % 2 == 0) ? 1 : 0) || gcyc[j] != 4 * j) begin
                tests_failed++; $display("FAIL rr_grant_%0d: got port %0d at c%0d expected port %0d at c%0d", j, order[j], gcyc[j], (j % 2 == 0) ? 1 : 0, 4 * j); end
        end
        tests_run++; if (exp_i_q.size() + exp_d_q.size() != 0) begin tests_failed++; $display("FAIL rr_drained: got %0d pending expected 0", exp_i_q.size() + exp_d_q.size()); end
    endtask

    task automatic test_reset_abort();
        int g;
        logic [31:0] e;
        req_i(32'h4, g);
        tests_run++; if (g != 0) begin tests_failed++; $display("FAIL abort_gnt: got %0d expected 0", g); end
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        tests_run++; if (bus.i_rvalid !== 1'b0) begin tests_failed++; $display("FAIL abort_rvalid_in_reset: got %b expected 0", bus.i_rvalid); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        tests_run++; if (u_dut.state !== ARB_IDLE) begin tests_failed++; $display("FAIL abort_state: got %0d expected %0d", u_dut.state, ARB_IDLE); end
        for (int k = 0; k < 3; k++) begin
            tests_run++; if (bus.i_rvalid !== 1'b0) begin tests_failed++; $display("FAIL abort_no_rvalid_%0d: got %b expected 0", k, bus.i_rvalid); end
            @(negedge clock);
        end
        req_i(32'h4, g);
        exp_i_q.push_back(32'h00A0_0113);
        tests_run++; if (g != 0) begin tests_failed++; $display("FAIL reissue_gnt: got %0d expected 0", g); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            tests_run++; if (bus.i_rvalid !== logic'(k == 3)) begin tests_failed++; $display("FAIL reissue_rvalid_c%0d: got %b expected %b", k, bus.i_rvalid, k == 3); end
            if (bus.i_rvalid === 1'b1 && exp_i_q.size() > 0) begin
                e = exp_i_q.pop_front();
                tests_run++; if (bus.i_rdata !== e) begin tests_failed++; $display("FAIL reissue_rdata: got %h expected %h", bus.i_rdata, e); end
            end
        end
        req_d(1'b1, 32'h808, WW_WORD, 32'hFFFF_FFFF, g);
        reset = 1'b1;
        @(negedge clock);
        tests_run++; if ({bus.mem_wenable, bus.d_wack} !== 2'b00) begin tests_failed++; $display("FAIL abort_write_strobes: got %b expected 00", {bus.mem_wenable, bus.d_wack}); end
        @(posedge clock); #1;
        reset = 1'b0;
        do_load_check("abort_write_load", 32'h808, 32'h1111_1111);
    endtask

    task automatic test_latency0();
        logic [31:0] e;
        @(posedge clock); #1;
        bus0.i_req = 1'b1; bus0.i_addr = 32'h0;
        exp0_q.push_back(32'h0050_0093);
        @(negedge clock);
        tests_run++; if (bus0.i_gnt !== 1'b1) begin tests_failed++; $display("FAIL l0_fetch_gnt: got %b expected 1", bus0.i_gnt); end
        @(posedge clock); #1;
        bus0.i_req = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock);
            tests_run++; if (bus0.i_rvalid !== logic'(k == 1)) begin tests_failed++; $display("FAIL l0_fetch_rvalid_c%0d: got %b expected %b", k, bus0.i_rvalid, k == 1); end
            if (bus0.i_rvalid === 1'b1 && exp0_q.size() > 0) begin
                e = exp0_q.pop_front();
                tests_run++; if (bus0.i_rdata !== e) begin tests_failed++; $display("FAIL l0_fetch_rdata: got %h expected %h", bus0.i_rdata, e); end
            end
        end
        @(posedge clock); #1;
        bus0.d_req = 1'b1; bus0.d_we = 1'b1; bus0.d_addr = 32'h800; bus0.d_wwidth = WW_WORD; bus0.d_wdata = 32'hCAFE_F00D;
        @(negedge clock);
        tests_run++; if (bus0.d_gnt !== 1'b1) begin tests_failed++; $display("FAIL l0_store_gnt: got %b expected 1", bus0.d_gnt); end
        @(posedge clock); #1;
        bus0.d_req = 1'b0;
        @(negedge clock);
        tests_run++; if ({bus0.mem_wenable, bus0.d_wack} !== 2'b11) begin tests_failed++; $display("FAIL l0_store_wack: got %b expected 11", {bus0.mem_wenable, bus0.d_wack}); end
        @(posedge clock); #1;
        bus0.d_req = 1'b1; bus0.d_we = 1'b0;
        @(negedge clock);
        tests_run++; if (bus0.d_gnt !== 1'b1) begin tests_failed++; $display("FAIL l0_load_gnt: got %b expected 1", bus0.d_gnt); end
        exp0_q.push_back(32'hCAFE_F00D);
        @(posedge clock); #1;
        bus0.d_req = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock);
            tests_run++; if (bus0.d_rvalid !== logic'(k == 1)) begin tests_failed++; $display("FAIL l0_load_rvalid_c%0d: got %b expected %b", k, bus0.d_rvalid, k == 1); end
            if (bus0.d_rvalid === 1'b1 && exp0_q.size() > 0) begin
                e = exp0_q.pop_front();
                tests_run++; if (bus0.d_rdata !== e) begin tests_failed++; $display("FAIL l0_load_rdata: got %h expected %h", bus0.d_rdata, e); end
            end
        end
        tests_run++; if (exp0_q.size() != 0) begin tests_failed++; $display("FAIL l0_drained: got %0d pending expected 0", exp0_q.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0; ref_mem[i] = '0; mem0[i] = '0;
        end
        mem[0] = 32'h0050_0093;   ref_mem[0] = 32'h0050_0093;   mem0[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;   ref_mem[1] = 32'h00A0_0113;
        mem[514] = 32'h1111_1111; ref_mem[514] = 32'h1111_1111;
        reset = 1'b1;
        bus.i_req = 1'b0;  bus.i_addr = '0;  bus.d_req = 1'b0;  bus.d_we = 1'b0;
        bus.d_addr = '0;   bus.d_wwidth = WW_WORD;  bus.d_wdata = '0;
        bus0.i_req = 1'b0; bus0.i_addr = '0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
        bus0.d_addr = '0;  bus0.d_wwidth = WW_WORD; bus0.d_wdata = '0;

        test_reset();
        test_fetch();
        test_store_load();
        test_byte_store();
        test_round_robin();
        test_reset_abort();
        test_latency0();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port memory (ROM+RAM, fixed read latency) between two requesters: instruction fetch (port I, read-only) and data load/store (port D, read/write). Requesters use a req/gnt handshake. The arbiter owns all memory control signals and sequences the read-latency countdown. Requesters no longer count cycles themselves. It sits between the hart's fetch/LSU logic and the memory module.

Parameters:
XLEN, 32, address/data width
READ_LATENCY, 2, extra cycles memory address must be held before mem_rdata is valid

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
i_req  in  1  fetch request; held until i_gnt
i_addr  in  XLEN  fetch address
i_gnt  out  1  fetch accepted (1-cycle pulse)
i_rvalid  out  1  i_rdata valid (1-cycle pulse)
i_rdata  out  XLEN  fetched instruction word
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  XLEN  data address
d_wwidth  in  write_width_t  store width (byte/halfword/word)
d_wdata  in  XLEN  store data
d_gnt  out  1  data accepted (1-cycle pulse)
d_rvalid  out  1  d_rdata valid (1-cycle pulse, loads only)
d_rdata  out  XLEN  load data
d_wack  out  1  store performed (1-cycle pulse)
mem_addr  out  XLEN  to memory
mem_wwidth  out  write_width_t  to memory
mem_wenable  out  1  to memory
mem_wdata  out  XLEN  to memory
mem_rdata  in  XLEN  from memory

Behaviour:
- States: IDLE, READ, WRITE. Reset: state=IDLE, owner=I, last_grant=I, count=READ_LATENCY. All gnt/rvalid/wack=0, mem_wenable=0.
- Grants occur only in IDLE. gnt is combinational in the IDLE cycle in which req is seen. At that edge, latch addr/we/wwidth/wdata and owner.
- Arbitration, single req: grant it. Both req: grant the port not in last_grant (round-robin). Reset value makes D win the first tie. last_grant updates on every grant.
- Read (i_req, or d_req with d_we=0): IDLE→READ, count=READ_LATENCY. In READ, mem_addr=latched addr. count decrements each cycle. In the cycle with count==0: owner rvalid=1, rdata=mem_rdata (combinational). Next edge→IDLE.
- Read occupancy: grant cycle + READ_LATENCY+1 cycles. With default, rvalid falls 3 cycles after gnt.
- Write (d_req, d_we=1): IDLE→WRITE. In WRITE (exactly one cycle), mem_addr/mem_wdata/mem_wwidth come from latches, mem_wenable=1, d_wack=1. Next edge→IDLE.
- Throughput: minimum one IDLE cycle between transactions. No back-to-back grant.
- mem_wenable=1 only in WRITE. mem_addr=latched addr in READ/WRITE. In IDLE, mem_addr=i_addr (don't-care to memory). mem_wdata don't-care except in WRITE.
- Requester drops req after gnt. req held high after gnt is treated as a new request in the next IDLE.
- rdata outputs are don't-care when rvalid=0. Alignment is not checked; addresses pass through.
- Reset mid-READ/WRITE: returns to IDLE next edge. No rvalid/wack for the aborted op. Reset cycle forces mem_wenable=0. Requesters must re-request.

Decomposition:
- Package mem_arb_types: port_id_t enum {PORT_I, PORT_D}; arb_state_t enum {ARB_IDLE, ARB_READ, ARB_WRITE}.
- write_width_t and XLEN stay in isa_types.
- One combinational sub-module rr_pick2 (inputs req[1:0], last_grant; output granted port, grant_valid), reusable for future requesters.

Test Plan:
- Reset, then i_req=1, i_addr=0x0 with memory word 0x00500093 -> i_gnt at cycle 0; i_rvalid only at cycle 3 with i_rdata=0x00500093; mem_wenable=0 throughout.
- d_req store: d_addr=0x800, d_wdata=0xDEADBEEF, word -> d_gnt cycle 0, mem_wenable=1 and d_wack=1 at cycle 1 only. Subsequent load from 0x800 -> d_rvalid with 0xDEADBEEF.
- i_req and d_req both high from reset -> D granted first, I granted at next IDLE, then I/D alternate while both held.
- Byte store d_wwidth=byte, d_addr=0x801, d_wdata=0x000000AA over 0xDEADBEEF -> later word load returns 0xDEADAAEF.
- Reset asserted in the second READ cycle -> no i_rvalid; state IDLE after reset. Re-issued i_req -> normal 3-cycle read.
- READ_LATENCY=0 build: fetch -> i_rvalid the cycle after i_gnt; store/load sequence still correct.
